// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, mode encoding and modular add/subtract helpers
// for the NTT butterfly datapath.
package ntt_pkg;
   localparam int N_DEF = 17;
   localparam int Q_DEF = 65537;
   localparam logic MODE_CT = 1'b0;
   localparam logic MODE_GS = 1'b1;

   function automatic logic [N_DEF-1:0] mod_add(input logic [N_DEF-1:0] a, b, q);
      logic [N_DEF:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= {1'b0, q}) ? N_DEF'(s - {1'b0, q}) : N_DEF'(s);
   endfunction

   function automatic logic [N_DEF-1:0] mod_sub(input logic [N_DEF-1:0] a, b, q);
      logic [N_DEF:0] d;
      d = {1'b0, a} - {1'b0, b};
      return d[N_DEF] ? N_DEF'(d + {1'b0, q}) : N_DEF'(d);
   endfunction
endpackage

// File: rtl/ntt_bfly_pipe_mod_mul.sv
// mod_mul: combinational full-width product reduced to [0,Q); the spot to
// drop in a Barrett or Montgomery reducer.
module mod_mul #(
   parameter int N = 17,
   parameter int Q = 65537
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] r
);
   localparam logic [2*N-1:0] QW = (2*N)'(Q);
   logic [2*N-1:0] p;
   assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
   assign r = N'(p % QW);
endmodule

// File: rtl/ntt_bfly_pipe.sv
// ntt_bfly_pipe: 3-stage CT/GS butterfly PE with valid/ready flow control.
// Define NTT_BFLY_INV_EN to build the GS (inverse) path; otherwise CT only.
module ntt_bfly_pipe
   import ntt_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int Q = Q_DEF,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_u,
   input  logic [N-1:0]     in_v,
   input  logic [N-1:0]     in_tf,
   input  logic             in_inv,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_x,
   output logic [N-1:0]     out_y,
   output logic [TAG_W-1:0] out_tag
);
   localparam logic [N-1:0] QM = N'(Q);

   logic             ld0, ld1, ld2;
   logic             s0_valid_q, s0_valid_d, s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [N-1:0]     s0_a_in, s0_b_in;
   logic             s0_inv_in;
   logic [N-1:0]     s0_a_q, s0_a_d, s0_b_q, s0_b_d, s0_tf_q, s0_tf_d;
   logic             s0_inv_q, s0_inv_d, s1_inv_q, s1_inv_d;
   logic [TAG_W-1:0] s0_tag_q, s0_tag_d, s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
   logic [N-1:0]     prod;
   logic [N-1:0]     s1_a_q, s1_a_d, s1_p_q, s1_p_d;
   logic [N-1:0]     s2_x_q, s2_x_d, s2_y_q, s2_y_d;
   logic             s2_load;

`ifdef NTT_BFLY_INV_EN
   assign s0_inv_in = (in_inv == MODE_GS) ? MODE_GS : MODE_CT;
   assign s0_a_in   = s0_inv_in ? mod_add(in_u, in_v, QM) : in_u;
   assign s0_b_in   = s0_inv_in ? mod_sub(in_u, in_v, QM) : in_v;
`else
   logic unused_inv;
   assign unused_inv = in_inv;
   assign s0_inv_in  = MODE_CT;
   assign s0_a_in    = in_u;
   assign s0_b_in    = in_v;
`endif

   mod_mul #(.N(N), .Q(Q)) u_mul (.a(s0_b_q), .b(s0_tf_q), .r(prod));

   // Ready ripples back combinationally: a stage loads if empty or draining.
   always_comb begin
      ld2 = !s2_valid_q | out_ready;
      ld1 = !s1_valid_q | ld2;
      ld0 = !s0_valid_q | ld1;
      s2_load = ld2 & s1_valid_q;
      s0_valid_d = ld0 ? in_valid : s0_valid_q;
      s1_valid_d = ld1 ? s0_valid_q : s1_valid_q;
      s2_valid_d = ld2 ? s1_valid_q : s2_valid_q;
      s0_a_d   = ld0 ? s0_a_in : s0_a_q;
      s0_b_d   = ld0 ? s0_b_in : s0_b_q;
      s0_tf_d  = ld0 ? in_tf : s0_tf_q;
      s0_inv_d = ld0 ? s0_inv_in : s0_inv_q;
      s0_tag_d = ld0 ? in_tag : s0_tag_q;
      s1_a_d   = ld1 ? s0_a_q : s1_a_q;
      s1_p_d   = ld1 ? prod : s1_p_q;
      s1_inv_d = ld1 ? s0_inv_q : s1_inv_q;
      s1_tag_d = ld1 ? s0_tag_q : s1_tag_q;
      s2_x_d   = s2_load ? ((s1_inv_q == MODE_GS) ? s1_a_q : mod_add(s1_a_q, s1_p_q, QM)) : s2_x_q;
      s2_y_d   = s2_load ? ((s1_inv_q == MODE_GS) ? s1_p_q : mod_sub(s1_a_q, s1_p_q, QM)) : s2_y_q;
      s2_tag_d = s2_load ? s1_tag_q : s2_tag_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid_q <= 1'b0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_x_q     <= '0;
         s2_y_q     <= '0;
         s2_tag_q   <= '0;
      end else begin
         s0_valid_q <= s0_valid_d;
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s2_x_q     <= s2_x_d;
         s2_y_q     <= s2_y_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   always_ff @(posedge clk) begin
      s0_a_q   <= s0_a_d;
      s0_b_q   <= s0_b_d;
      s0_tf_q  <= s0_tf_d;
      s0_inv_q <= s0_inv_d;
      s0_tag_q <= s0_tag_d;
      s1_a_q   <= s1_a_d;
      s1_p_q   <= s1_p_d;
      s1_inv_q <= s1_inv_d;
      s1_tag_q <= s1_tag_d;
   end

   assign in_ready  = ld0;
   assign out_valid = s2_valid_q;
   assign out_x     = s2_x_q;
   assign out_y     = s2_y_q;
   assign out_tag   = s2_tag_q;
endmodule

// File: tb/tb_ntt_bfly_pipe.sv
// tb_ntt_bfly_pipe: directed table, streaming, backpressure and reset tests
// for ntt_bfly_pipe against a % based reference model.
module tb_ntt_bfly_pipe;
   localparam longint QL = 65537;
`ifdef NTT_BFLY_INV_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, in_ready, in_inv = 1'b0, out_valid, out_ready = 1'b1;
   logic [16:0] in_u = '0, in_v = '0, in_tf = '0, out_x, out_y;
   logic [7:0] in_tag = '0, out_tag;

   ntt_bfly_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_u(in_u), .in_v(in_v), .in_tf(in_tf), .in_inv(in_inv), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
      .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [16:0] u, v, tf;
      logic        inv;
      logic [7:0]  tag;
      logic [16:0] x, y, xc, yc;
   } vec_t;
   typedef struct {
      logic [16:0] x, y;
      logic [7:0]  tag;
   } exp_t;

   vec_t vt[5];
   exp_t sb[$];
   int chk = 0, err = 0;
   int nsent, nrecv, ncyc = 0, first_rc, last_rc;
   bit hold_prev = 0;
   logic [16:0] px, py;
   logic [7:0] ptag;
   logic [16:0] ru[100], rv[100], rt[100];
   logic ri[100];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [16:0] u, v, tf, input logic inv, input logic [7:0] tag);
      longint lu, lv, lt, t;
      exp_t e;
      lu = longint'(u);
      lv = longint'(v);
      lt = longint'(tf);
      if (inv && INV_EN) begin
         e.x = 17'((lu + lv) % QL);
         t = (lu - lv + QL) % QL;
         e.y = 17'((t * lt) % QL);
      end else begin
         t = (lv * lt) % QL;
         e.x = 17'((lu + t) % QL);
         e.y = 17'((lu - t + QL) % QL);
      end
      e.tag = tag;
      return e;
   endfunction

   task automatic cyc(output bit acc);
      exp_t e;
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
         sb.push_back(model(in_u, in_v, in_tf, in_inv, in_tag));
         nsent++;
      end
      if (hold_prev) begin
         check("hold_x", out_x, px);
         check("hold_y", out_y, py);
         check("hold_tag", out_tag, ptag);
      end
      hold_prev = out_valid && !out_ready;
      px = out_x;
      py = out_y;
      ptag = out_tag;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk++;
            err++;
            $display("FAIL unexpected_out: got tag %0d expected none", out_tag);
         end else begin
            e = sb.pop_front();
            check("sb_x", out_x, e.x);
            check("sb_y", out_y, e.y);
            check("sb_tag", out_tag, e.tag);
         end
         if (nrecv == 0) first_rc = ncyc;
         last_rc = ncyc;
         nrecv++;
      end
      ncyc++;
      @(negedge clk);
   endtask

   task automatic set_rand(input int i);
      in_u = ru[i];
      in_v = rv[i];
      in_tf = rt[i];
      in_inv = ri[i];
      in_tag = 8'(i);
   endtask

   task automatic gen_rand();
      for (int i = 0; i < 100; i++) begin
         ru[i] = 17'($urandom_range(0, 65536));
         rv[i] = 17'($urandom_range(0, 65536));
         rt[i] = 17'($urandom_range(0, 65536));
         ri[i] = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit acc;
      int acc3, drops, vcnt;
      vt[0] = '{u:5,     v:3,     tf:2,     inv:0, tag:8'h11, x:11, y:65536, xc:11, yc:65536};
      vt[1] = '{u:5,     v:3,     tf:2,     inv:1, tag:8'h22, x:8,  y:4,     xc:11, yc:65536};
      vt[2] = '{u:3,     v:5,     tf:2,     inv:1, tag:8'h33, x:8,  y:65533, xc:13, yc:65530};
      vt[3] = '{u:65536, v:1,     tf:1,     inv:0, tag:8'h44, x:0,  y:65535, xc:0,  yc:65535};
      vt[4] = '{u:0,     v:65536, tf:65536, inv:0, tag:8'h55, x:1,  y:65536, xc:1,  yc:65536};

      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_x", out_x, 0);
      check("rst_out_y", out_y, 0);
      check("rst_out_tag", out_tag, 0);
      rst_n = 1'b1;
      @(negedge clk);
      #1 check("rst_in_ready", in_ready, 1);
      @(negedge clk);

      nsent = 0;
      nrecv = 0;
      for (int i = 0; i < 5; i++) begin
         in_u = vt[i].u;
         in_v = vt[i].v;
         in_tf = vt[i].tf;
         in_inv = vt[i].inv;
         in_tag = vt[i].tag;
         in_valid = 1'b1;
         out_ready = 1'b1;
         cyc(acc);
         check("vec_accept", acc, 1);
         in_valid = 1'b0;
         check("vec_lat1", out_valid, 0);
         cyc(acc);
         check("vec_lat2", out_valid, 0);
         cyc(acc);
         check("vec_lat3", out_valid, 1);
         check("vec_x", out_x, INV_EN ? vt[i].x : vt[i].xc);
         check("vec_y", out_y, INV_EN ? vt[i].y : vt[i].yc);
         check("vec_tag", out_tag, vt[i].tag);
         cyc(acc);
      end
      check("vec_sb_empty", sb.size(), 0);

      gen_rand();
      nsent = 0;
      nrecv = 0;
      drops = 0;
      for (int c = 0; c < 400 && nrecv < 100; c++) begin
         in_valid = nsent < 100;
         if (nsent < 100) set_rand(nsent);
         out_ready = 1'b1;
         cyc(acc);
         if (in_valid && !acc) drops++;
      end
      in_valid = 1'b0;
      check("stream_count", nrecv, 100);
      check("stream_span", last_rc - first_rc + 1, 100);
      check("stream_stalls", drops, 0);
      check("stream_sb_empty", sb.size(), 0);

      gen_rand();
      nsent = 0;
      nrecv = 0;
      acc3 = 0;
      for (int c = 0; c < 200 && nrecv < 20; c++) begin
         in_valid = nsent < 20;
         if (nsent < 20) set_rand(nsent);
         out_ready = !((c < 5) || (c >= 12 && c < 17));
         #1;
         if (c == 4) check("bp_full_ready", in_ready, 0);
         if (c == 5) check("bp_release_ready", in_ready, 1);
         cyc(acc);
         if (c < 5 && acc) acc3++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("bp_accepts", acc3, 3);
      check("bp_count", nrecv, 20);
      check("bp_sent", nsent, 20);
      check("bp_sb_empty", sb.size(), 0);

      nsent = 0;
      nrecv = 0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_u = 17'(100 + i);
         in_v = 17'(7);
         in_tf = 17'(3);
         in_inv = 1'b0;
         in_tag = 8'(i + 1);
         cyc(acc);
      end
      in_valid = 1'b0;
      check("rst_mid_inflight", nsent, 2);
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", out_valid, 0);
      check("rst_mid_out_x", out_x, 0);
      check("rst_mid_out_y", out_y, 0);
      check("rst_mid_out_tag", out_tag, 0);
      sb.delete();
      hold_prev = 0;
      @(negedge clk);
      rst_n = 1'b1;
      vcnt = 0;
      for (int c = 0; c < 6; c++) begin
         #1 if (out_valid) vcnt++;
         cyc(acc);
      end
      check("rst_no_stale", vcnt, 0);
      #1 check("rst_post_ready", in_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end
endmodule

// File: doc/ntt_bfly_pipe.md
# ntt_bfly_pipe

Pipelined, parametrised NTT/INTT butterfly processing element. It accepts one (u, v, twiddle) triple per cycle under a valid/ready handshake and returns both butterfly outputs reduced mod Q after a fixed latency. Per-transaction mode selects Cooley-Tukey (forward NTT) or Gentleman-Sande (inverse NTT). It replaces the single-output combinational PE cell inside the NTT datapath, between the coefficient-memory read port and the write-back buffer.

## Interface
- N, 17, coefficient width in bits; every operand and result is N bits.
- Q, 65537, modulus; Q < 2^N; Q odd.
- TAG_W, 8, width of a sideband tag carried unchanged with each transaction (address/index).
- clk  input  1  clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  an input triple is presented.
- in_ready  output  1  the block accepts the triple this cycle.
- in_u  input  N  butterfly top operand, < Q.
- in_v  input  N  butterfly bottom operand, < Q.
- in_tf  input  N  twiddle factor, < Q.
- in_inv  input  1  0 = NTT (CT), 1 = INTT (GS).
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  a result pair is presented.
- out_ready  input  1  downstream accepts the result pair.
- out_x  output  N  top result.
- out_y  output  N  bottom result.
- out_tag  output  TAG_W  tag of the result pair.

## Operation
- CT (inv=0): t = v·tf mod Q; x = (u+t) mod Q; y = (u−t) mod Q.
- GS (inv=1): x = (u+v) mod Q; y = ((u−v) mod Q)·tf mod Q.
- Modular add: s = u+v (N+1 bits); if s ≥ Q then s−Q.
- Modular subtract: d = u−v; if negative then d+Q.
- Modular multiply: full 2N-bit product, reduced to [0,Q) by mod_mul.
- Out-of-range operands (≥ Q) give undefined results; the block does not check them.
- Stage 0 register: operands, mode, tag. In GS mode the add/sub is computed here.
- Stage 1 register: the product (CT: v·tf; GS: (u−v)·tf), reduced.
- Stage 2 register: in CT mode the final add/sub is done here; in GS mode x and y pass through. This is the output register.
- Each stage has a valid bit. A stage loads when it is empty or when its contents move forward in the same cycle.
- in_ready = !s0_valid | s0 advances, where s2 advances when out_ready is 1. Ready propagates combinationally backward through the three stages; there is no skid buffer.
- Mixed CT/GS transactions may be interleaved back to back; mode travels with the data.

## Timing
- Latency is 3 cycles from an accepted input (in_valid & in_ready) to out_valid, with no stalls.
- Sustained throughput is 1 pair per cycle while out_ready stays high.
- A handshake occurs on a cycle where valid and ready are both high. out_x, out_y and out_tag hold stable while out_valid & !out_ready.
- Reset state: all stage valid bits are 0; out_valid=0; out_x=0, out_y=0, out_tag=0; in_ready=1 from the first cycle after reset release.
- Full pipeline with out_ready=0: in_ready=0. The same cycle out_ready rises, in_ready=1, so a simultaneous accept and drain loses no cycle.
- Reset asserted mid-operation: all in-flight transactions are discarded; no partial output appears after release.
- Data registers are not reset except the stage-2 outputs.

## Configuration
- NTT_BFLY_INV_EN defined: both CT and GS paths are built, and in_inv selects between them per transaction.
- NTT_BFLY_INV_EN undefined: only CT is built; in_inv is ignored (treated as 0) and the GS add/sub and operand mux are removed. Latency and handshake are unchanged.

## Structure
- Package ntt_pkg holds:
  - the default N and Q constants;
  - the mode encoding constants MODE_CT=0 and MODE_GS=1;
  - a function for modular add and one for modular subtract (N-bit, parametrised by Q).
- Sub-module mod_mul (N, Q): a combinational 2N-bit product plus reduction to [0,Q). It is instantiated once, in stage 1. It is the natural place to swap in Barrett or Montgomery reduction later.

## Test plan
- CT, u=5, v=3, tf=2, tag=0x11 -> after 3 cycles x=11, y=65536, tag=0x11.
- GS, u=5, v=3, tf=2 -> x=8, y=4. Then u=3, v=5, tf=2 -> x=8, y=65533.
- Wrap: CT, u=65536, v=1, tf=1 -> x=0, y=65535. CT, u=0, v=65536, tf=65536 -> t=1, x=1, y=65536.
- Streaming: 100 random CT/GS triples back to back with out_ready=1 -> 100 outputs on consecutive cycles, in order, matching the reference model.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream -> in_ready drops after 3 accepts, outputs stay stable, and no transaction is lost or duplicated after release.
- Assert rst_n with 2 transactions in flight -> out_valid=0 and outputs are 0 immediately; after release, no stale results appear and in_ready=1.
